// File: rtl/multdiv_booth_seq_if.sv
// Signal bundle for the sequential Booth multiplier: the host-side
// request/response signals plus the time-shared execute-stage ALU hookup.
// The slave modport is the multiplier's view; master is the environment's.
interface multdiv_booth_seq_if;
  // Host request
  logic        ctrl_MULT;
  logic        ctrl_flush;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  // Host response
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;
  // Shared ALU
  logic [31:0] alu_operandA;
  logic [31:0] alu_operandB;
  logic [4:0]  alu_opcode;
  logic [4:0]  alu_shiftamt;
  logic [31:0] alu_result;
  logic        alu_overflow;

  modport slave (
    input  ctrl_MULT, ctrl_flush, data_operandA, data_operandB,
    input  alu_result, alu_overflow,
    output data_result, data_exception, data_resultRDY, busy,
    output alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
  );

  modport master (
    output ctrl_MULT, ctrl_flush, data_operandA, data_operandB,
    output alu_result, alu_overflow,
    input  data_result, data_exception, data_resultRDY, busy,
    input  alu_operandA, alu_operandB, alu_opcode, alu_shiftamt
  );
endinterface

// File: rtl/multdiv_booth_seq.sv
// Multi-cycle signed 32x32 multiplier, radix-2 Booth, one step per clock.
// Borrows the execute-stage ALU for the add/subtract of each step and
// returns the low 32 product bits plus an overflow exception.
module multdiv_booth_seq #(
  parameter int N_STEPS = 32
) (
  input logic              clock,
  input logic              reset,
  multdiv_booth_seq_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;

  state_t      state, state_nxt;
  logic [31:0] m;
  logic [31:0] p_hi;
  logic [31:0] p_lo;
  logic        q_m1;
  logic [5:0]  cnt;
  logic [31:0] result_q;
  logic        exception_q;

  logic [31:0] sum;
  logic        true_sign;
  logic [31:0] p_hi_nxt;
  logic [31:0] p_lo_nxt;
  logic        load;
  logic        last_step;
  logic        step;

  assign last_step = (cnt == 6'(N_STEPS - 1));
  assign step      = (state == RUN) && !bus.ctrl_flush;

  // Next-state decode and ALU drive for the current Booth step.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_nxt        = state;
    load             = 1'b0;
    bus.alu_operandA = '0;
    bus.alu_operandB = '0;
    bus.alu_opcode   = OP_ADD;
    sum              = p_hi;
    true_sign        = p_hi[31];

    case (state)
      IDLE, DONE: begin
        if (bus.ctrl_flush) begin
          state_nxt = IDLE;
        end else if (bus.ctrl_MULT) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        bus.alu_operandA = p_hi;
        case ({p_lo[0], q_m1})
          2'b01: begin
            bus.alu_operandB = m;
            sum              = bus.alu_result;
            // Overflow flips the visible sign; xor recovers the 33rd bit.
            true_sign        = bus.alu_result[31] ^ bus.alu_overflow;
          end
          2'b10: begin
            bus.alu_operandB = m;
            bus.alu_opcode   = OP_SUB;
            sum              = bus.alu_result;
            true_sign        = bus.alu_result[31] ^ bus.alu_overflow;
          end
          default: ;
        endcase
        if (bus.ctrl_flush)  state_nxt = IDLE;
        else if (last_step)  state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase

    // 65-bit arithmetic shift right of {true_sign, sum, p_lo}.
    p_hi_nxt = {true_sign, sum[31:1]};
    p_lo_nxt = {sum[0], p_lo[31:1]};
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operand load and per-step partial-product update.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      m    <= '0;
      p_hi <= '0;
      p_lo <= '0;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (load) begin
      m    <= bus.data_operandA;
      p_hi <= '0;
      p_lo <= bus.data_operandB;
      q_m1 <= 1'b0;
      cnt  <= '0;
    end else if (step) begin
      p_hi <= p_hi_nxt;
      p_lo <= p_lo_nxt;
      q_m1 <= p_lo[0];
      cnt  <= cnt + 6'd1;
    end
  end

  // Result capture on the final step; held until the next completion.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      result_q    <= '0;
      exception_q <= 1'b0;
    end else if (step && last_step) begin
      result_q    <= p_lo_nxt;
      exception_q <= (p_hi_nxt != {32{p_lo_nxt[31]}});
    end
  end

  assign bus.alu_shiftamt   = '0;
  assign bus.busy           = (state == RUN);
  assign bus.data_resultRDY = (state == DONE);
  assign bus.data_result    = result_q;
  assign bus.data_exception = exception_q;

endmodule

// File: tb/tb_multdiv_booth_seq.sv
// Bench for multdiv_booth_seq: a behavioural ALU, a product-level reference
// model compared every cycle, directed literal cases and randomized traffic.
module tb_multdiv_booth_seq;

  logic clock = 1'b0;
  logic reset;

  multdiv_booth_seq_if bus ();

  multdiv_booth_seq #(.N_STEPS(32)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  // Behavioural execute-stage ALU: ADD / SUBTRACT with signed overflow.
  logic [31:0] alu_sum;
  logic        alu_is_sub;
  assign alu_is_sub = (bus.alu_opcode == 5'b00001);
  assign alu_sum    = alu_is_sub ? bus.alu_operandA - bus.alu_operandB
                                 : bus.alu_operandA + bus.alu_operandB;
  assign bus.alu_result   = alu_sum;
  assign bus.alu_overflow = alu_is_sub
    ? (bus.alu_operandA[31] != bus.alu_operandB[31]) && (alu_sum[31] != bus.alu_operandA[31])
    : (bus.alu_operandA[31] == bus.alu_operandB[31]) && (alu_sum[31] != bus.alu_operandA[31]);

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: exact 64-bit signed product; exception when it leaves int32 range.
  function automatic logic [32:0] model_mul(input logic [31:0] a, input logic [31:0] b);
    longint p;
    logic   exc;
    p   = longint'($signed(a)) * longint'($signed(b));
    exc = (p > 64'sd2147483647) || (p < -64'sd2147483648);
    return {exc, p[31:0]};
  endfunction

  // Operation-level model: an accepted start completes 32 edges later.
  int          mdl_left   = 0;
  logic        mdl_rdy    = 1'b0;
  logic [31:0] mdl_result = '0;
  logic        mdl_exc    = 1'b0;
  logic [32:0] mdl_pend   = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mdl_left   <= 0;
      mdl_rdy    <= 1'b0;
      mdl_result <= '0;
      mdl_exc    <= 1'b0;
    end else if (mdl_left > 0) begin
      mdl_rdy <= 1'b0;
      if (bus.ctrl_flush) begin
        mdl_left <= 0;
      end else begin
        mdl_left <= mdl_left - 1;
        if (mdl_left == 1) begin
          mdl_rdy    <= 1'b1;
          mdl_result <= mdl_pend[31:0];
          mdl_exc    <= mdl_pend[32];
        end
      end
    end else begin
      mdl_rdy <= 1'b0;
      if (!bus.ctrl_flush && bus.ctrl_MULT) begin
        mdl_left <= 32;
        mdl_pend <= model_mul(bus.data_operandA, bus.data_operandB);
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    check("busy",      32'(bus.busy),           32'(mdl_left > 0));
    check("rdy",       32'(bus.data_resultRDY), 32'(mdl_rdy));
    check("result",    bus.data_result,         mdl_result);
    check("exception", 32'(bus.data_exception), 32'(mdl_exc));
    check("shiftamt",  32'(bus.alu_shiftamt),   32'd0);
    if (mdl_left == 0) begin
      check("idle_alu_a",  bus.alu_operandA,      32'd0);
      check("idle_alu_b",  bus.alu_operandB,      32'd0);
      check("idle_alu_op", 32'(bus.alu_opcode),   32'd0);
    end
  end

  // Presents a start; caller must be away from a rising edge.
  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    bus.data_operandA = a;
    bus.data_operandB = b;
    bus.ctrl_MULT     = 1'b1;
    @(posedge clock);
    #1;
    bus.ctrl_MULT     = 1'b0;
  endtask

  // Counts falling edges until RDY (cyc=0 if it never comes), optionally
  // injecting a stray start (9*9) or a flush at given cycle numbers.
  task automatic wait_rdy(input int max_cyc, input int mult_at, input int flush_at,
                          output int cyc, output int busy_cnt, output logic busy_after_flush);
    cyc = 0;
    busy_cnt = 0;
    busy_after_flush = 1'b1;
    for (int k = 1; k <= max_cyc; k++) begin
      @(negedge clock);
      bus.ctrl_MULT  = 1'b0;
      bus.ctrl_flush = 1'b0;
      if (bus.busy) busy_cnt++;
      if (k == flush_at + 1) busy_after_flush = bus.busy;
      if (bus.data_resultRDY) begin
        cyc = k;
        return;
      end
      if (k == mult_at) begin
        bus.data_operandA = 32'd9;
        bus.data_operandB = 32'd9;
        bus.ctrl_MULT     = 1'b1;
      end
      if (k == flush_at) bus.ctrl_flush = 1'b1;
    end
  endtask

  task automatic run_lit(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input logic exp_exc);
    int   cyc, bc;
    logic baf;
    @(negedge clock);
    start_op(a, b);
    wait_rdy(60, -1, -1, cyc, bc, baf);
    check({name, "_latency"}, 32'(cyc), 32'd33);
    check({name, "_busy_cycles"}, 32'(bc), 32'd32);
    check({name, "_result"}, bus.data_result, exp_res);
    check({name, "_exc"}, 32'(bus.data_exception), 32'(exp_exc));
  endtask

  logic [31:0] extremes [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                                32'h7FFF_FFFF, 32'h0001_0000};

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 3))
      0:       return $urandom();
      1:       return 32'($signed($urandom_range(0, 200)) - 100);
      2:       return extremes[$urandom_range(0, 5)];
      default: return $urandom() >> $urandom_range(0, 31);
    endcase
  endfunction

  initial begin
    int   cyc, bc, fa;
    logic baf;
    bus.ctrl_MULT     = 1'b0;
    bus.ctrl_flush    = 1'b0;
    bus.data_operandA = '0;
    bus.data_operandB = '0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_result", bus.data_result, 32'd0);
    check("rst_exc",    32'(bus.data_exception), 32'd0);
    check("rst_rdy",    32'(bus.data_resultRDY), 32'd0);
    check("rst_busy",   32'(bus.busy), 32'd0);
    reset = 1'b0;

    run_lit("m3x5",       32'd3,          32'd5,          32'h0000_000F, 1'b0);
    run_lit("mneg7x6",    32'hFFFF_FFF9,  32'd6,          32'hFFFF_FFD6, 1'b0);
    run_lit("mminx1",     32'h8000_0000,  32'd1,          32'h8000_0000, 1'b0);
    run_lit("mminxneg1",  32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000, 1'b1);
    run_lit("m64kx64k",   32'h0001_0000,  32'h0001_0000,  32'h0000_0000, 1'b1);

    // Stray start during RUN is ignored; a start in the RDY cycle is accepted.
    @(negedge clock);
    start_op(32'd3, 32'd5);
    wait_rdy(60, 10, -1, cyc, bc, baf);
    check("ignore_latency", 32'(cyc), 32'd33);
    check("ignore_result",  bus.data_result, 32'd15);
    start_op(32'd2, 32'd2);
    wait_rdy(60, -1, -1, cyc, bc, baf);
    check("b2b_latency", 32'(cyc), 32'd33);
    check("b2b_result",  bus.data_result, 32'd4);

    // Flush mid-run: no RDY, outputs keep the previous result.
    @(negedge clock);
    start_op(32'd7, 32'd7);
    wait_rdy(45, -1, 12, cyc, bc, baf);
    check("flush_no_rdy",     32'(cyc), 32'd0);
    check("flush_busy_after", 32'(baf), 32'd0);
    check("flush_keep_res",   bus.data_result, 32'd4);

    // Asynchronous reset between edges mid-run.
    @(negedge clock);
    start_op(32'd11, 32'd13);
    repeat (19) @(negedge clock);
    check("pre_reset_busy", 32'(bus.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_result", bus.data_result, 32'd0);
    check("async_rst_exc",    32'(bus.data_exception), 32'd0);
    check("async_rst_rdy",    32'(bus.data_resultRDY), 32'd0);
    check("async_rst_busy",   32'(bus.busy), 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    run_lit("m4xneg4", 32'd4, 32'hFFFF_FFFC, 32'hFFFF_FFF0, 1'b0);

    // Randomized traffic: mixed operands, back-to-back starts, random flushes.
    @(negedge clock);
    for (int i = 0; i < 60; i++) begin
      fa = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 32)) : -1;
      start_op(pick_operand(), pick_operand());
      wait_rdy(45, -1, fa, cyc, bc, baf);
      check("rand_latency", 32'(cyc), (fa < 0) ? 32'd33 : 32'd0);
      if (cyc == 0 || $urandom_range(0, 1) == 0) begin
        repeat ($urandom_range(1, 3)) @(negedge clock);
      end
    end
    repeat (3) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
